// File: rtl/fifo_param_pkg.sv
// Shared FIFO constants and the operation encoding used by the pointer/count logic.
// Sibling FIFOs and the bench import the same defaults from here.
package fifo_param_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_param_memoria.sv
// Dual-port DEPTH x DATA_WIDTH storage: synchronous write, registered read.
// Only the read register is reset; the array keeps whatever it held.
module memoria_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_enable) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // A same-edge write to rd_ptr (full FIFO, push+pop) returns the old word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_enable) begin
            rd_data_d = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: internal pointers, occupancy count, threshold flags,
// read-valid strobe and sticky overflow/underflow error around memoria_param.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  push_ok;
    logic                  pop_ok;
    fifo_op_e              op;

    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= umbral_alto);
    assign almost_empty = (count_q <= umbral_bajo);

    // Acceptance uses the registered count; a pop frees the slot a push on full needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        op       = OP_IDLE;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = pop_ok;
        error_d  = error_q | (push && !push_ok) | (pop && !pop_ok);

        if (push_ok && pop_ok) begin
            op = OP_BOTH;
        end else if (push_ok) begin
            op = OP_PUSH;
        end else if (pop_ok) begin
            op = OP_POP;
        end

        case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    memoria_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_enable (push_ok),
        .wr_ptr    (wr_ptr_q),
        .data_in   (data_in),
        .rd_enable (pop_ok),
        .rd_ptr    (rd_ptr_q),
        .rd_data   (data_out)
    );

    assign count     = count_q;
    assign valid_out = valid_q;
    assign error     = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_param;
    import fifo_param_pkg::*;

    localparam int DW    = DEF_DATA_WIDTH;
    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int total = 0;
    int bad   = 0;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the last popped word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_err   = 1'b0;
    bit            m_push_ok;
    bit            m_pop_ok;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_pop_ok  = pop && (mq.size() > 0);
            m_push_ok = push && ((mq.size() < DEPTH) || m_pop_ok);
            if (m_pop_ok) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_push_ok) mq.push_back(data_in);
            if ((push && !m_push_ok) || (pop && !m_pop_ok)) m_err = 1'b1;
        end
    end

    bit compare_on = 1'b0;

    always @(negedge clk) begin
        if (compare_on) begin
            check("data_out",     32'(data_out),     32'(m_dout));
            check("valid_out",    32'(valid_out),    32'(m_valid));
            check("count",        32'(count),        32'(mq.size()));
            check("full",         32'(full),         32'(mq.size() == DEPTH));
            check("empty",        32'(empty),        32'(mq.size() == 0));
            check("almost_full",  32'(almost_full),  32'(mq.size() >= int'(umbral_alto)));
            check("almost_empty", 32'(almost_empty), 32'(mq.size() <= int'(umbral_bajo)));
            check("error",        32'(error),        32'(m_err));
        end
    end

    task automatic cyc(input logic p, input logic po, input logic [DW-1:0] d);
        push    = p;
        pop     = po;
        data_in = d;
        @(posedge clk);
        #1;
        $display("cyc t=%0t push=%0b pop=%0b din=%03h -> count=%0d dout=%03h valid=%0b err=%0b",
                 $time, p, po, d, count, data_out, valid_out, error);
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("reset t=%0t", $time);
    endtask

    initial begin
        reset       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'(DEPTH);
        umbral_bajo = '0;
        #1;
        compare_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_dout",  32'(data_out), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;

        // Fill and drain
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, DW'(i));
        check("fill_full",  32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("drain_valid", 32'(valid_out), 32'd1);
            check("drain_data",  32'(data_out), 32'(i));
        end
        cyc(1'b0, 1'b0, '0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_hold",  32'(data_out), 32'h008);
        check("drain_idle",  32'(valid_out), 32'd0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(10'h3A0 + i));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("wrap1_data", 32'(data_out), 32'(10'h3A0 + i));
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, DW'(10'h3A0 + i));
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("wrap2_data", 32'(data_out), 32'(10'h3A0 + i));
        end
        check("wrap_error", 32'(error), 32'd0);

        // Overflow then underflow
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(10'h100 + i));
        cyc(1'b1, 1'b0, 10'h3FF);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_error", 32'(error), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("ovf_data", 32'(data_out), 32'(10'h100 + i));
        end
        do_reset();
        check("clr_error", 32'(error), 32'd0);
        cyc(1'b0, 1'b1, '0);
        check("udf_valid", 32'(valid_out), 32'd0);
        check("udf_error", 32'(error), 32'd1);

        // Thresholds
        do_reset();
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        #1;
        check("thr_ae0", 32'(almost_empty), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b0, DW'(10'h050 + k));
            check("thr_ae", 32'(almost_empty), 32'(k <= 2));
            check("thr_af", 32'(almost_full), 32'(k >= 6));
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, '0);
        check("thr_ae_back", 32'(almost_empty), 32'd1);
        check("thr_af_off",  32'(almost_full), 32'd0);
        umbral_alto = 4'd9;
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, DW'(k));
        check("thr_af_over", 32'(almost_full), 32'd0);

        // Concurrent push+pop on full, then on empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(10'h200 + i));
        cyc(1'b1, 1'b1, 10'h155);
        check("both_full_count", 32'(count), 32'd8);
        check("both_full_error", 32'(error), 32'd0);
        check("both_full_data",  32'(data_out), 32'h200);
        for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b1, '0);
        check("both_pre_last", 32'(data_out), 32'h207);
        cyc(1'b0, 1'b1, '0);
        check("both_last", 32'(data_out), 32'h155);
        cyc(1'b1, 1'b1, 10'h0AA);
        check("both_empty_count", 32'(count), 32'd1);
        check("both_empty_error", 32'(error), 32'd1);
        check("both_empty_valid", 32'(valid_out), 32'd0);

        // Randomized traffic
        begin
            int pp = 50;
            int pq = 50;
            for (int n = 0; n < 2000; n++) begin
                if (n % 100 == 0) begin
                    pp = $urandom_range(15, 85);
                    pq = $urandom_range(15, 85);
                end
                if (n % 37 == 0) begin
                    umbral_alto = 4'($urandom_range(0, 15));
                    umbral_bajo = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    cyc(1'($urandom_range(0, 99) < pp), 1'($urandom_range(0, 99) < pq), DW'($urandom));
                end
            end
        end

        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
